// File: rtl/dp_ram_be_init.sv
// Dual-clock dual-port RAM with per-lane byte enables, sequential clear engine,
// selectable read latency (1 or 2) and optional per-lane even parity.
`timescale 1ns/1ps
module dp_ram_be_init #(
  parameter int lane_width   = 8,
  parameter int num_lanes    = 4,
  parameter int addr_width   = 6,
  parameter int read_latency = 1,
  parameter int parity_en    = 1
) (
  input  logic                              wt_clk_dp_ram,
  input  logic                              wt_rst_n_dp_ram_in,
  input  logic                              rd_clk_dp_ram,
  input  logic                              rd_rst_n_dp_ram_in,
  input  logic                              wt_en_dp_ram,
  input  logic [num_lanes-1:0]              wt_be,
  input  logic [addr_width-1:0]             wt_addr,
  input  logic [lane_width*num_lanes-1:0]   data_in_dp_ram,
  input  logic                              clr_req,
  output logic                              wt_ready,
  output logic                              init_done,
  output logic                              wt_drop,
  input  logic                              rd_en_dp_ram,
  input  logic [addr_width-1:0]             rd_addr,
  output logic [lane_width*num_lanes-1:0]   data_out_dp_ram,
  output logic                              rd_valid,
  output logic [num_lanes-1:0]              rd_parity_err
);

  localparam int W     = lane_width * num_lanes;
  localparam int DEPTH = 1 << addr_width;

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} wt_state_t;

  wt_state_t             state_r;
  wt_state_t             state_nxt_s;
  logic [addr_width-1:0] clr_ptr_r;
  logic                  wt_ready_r;
  logic                  init_done_r;
  logic                  wt_drop_r;
  logic [W-1:0]          mem_r [DEPTH];
  logic [num_lanes-1:0]  rd_par_s;
  logic [num_lanes-1:0]  rd_err_s;
  logic [W-1:0]          s1_data_r;
  logic                  s1_vld_r;
  logic [num_lanes-1:0]  s1_err_r;

  function automatic logic [num_lanes-1:0] lane_parity(input logic [W-1:0] word);
    logic [num_lanes-1:0] p;
    p = '0;
    for (int k = 0; k < num_lanes; k++) begin
      p[k] = ^word[k*lane_width +: lane_width];
    end
    return p;
  endfunction

  // Write FSM next state: sweep to the last address, then serve writes until a clear request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_ptr_r == addr_width'(DEPTH - 1)) state_nxt_s = ST_READY;
        else                                     state_nxt_s = ST_CLEAR;
      end
      ST_READY: begin
        if (clr_req) state_nxt_s = ST_CLEAR;
        else         state_nxt_s = ST_READY;
      end
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // Write FSM state, clear pointer and registered write-side status.
  always_ff @(posedge wt_clk_dp_ram or negedge wt_rst_n_dp_ram_in) begin
    if (!wt_rst_n_dp_ram_in) begin
      state_r     <= ST_CLEAR;
      clr_ptr_r   <= '0;
      wt_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
      wt_drop_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_ptr_r   <= (state_r == ST_CLEAR) ? clr_ptr_r + addr_width'(1) : '0;
      wt_ready_r  <= (state_nxt_s == ST_READY);
      init_done_r <= (state_nxt_s == ST_READY);
      wt_drop_r   <= wt_en_dp_ram && !wt_ready_r;
    end
  end

  // Data array: clear sweep has priority; otherwise lane-masked writes.
  always_ff @(posedge wt_clk_dp_ram) begin
    if (state_r == ST_CLEAR) begin
      mem_r[clr_ptr_r] <= '0;
    end else if (wt_en_dp_ram) begin
      for (int k = 0; k < num_lanes; k++) begin
        if (wt_be[k]) mem_r[wt_addr][k*lane_width +: lane_width] <= data_in_dp_ram[k*lane_width +: lane_width];
      end
    end
  end

  generate
    if (parity_en != 0) begin : g_par
      logic [num_lanes-1:0] par_r [DEPTH];
      logic [num_lanes-1:0] wr_par_s;
      assign wr_par_s = lane_parity(data_in_dp_ram);
      // Parity array tracks the data array lane for lane.
      always_ff @(posedge wt_clk_dp_ram) begin
        if (state_r == ST_CLEAR) begin
          par_r[clr_ptr_r] <= '0;
        end else if (wt_en_dp_ram) begin
          for (int k = 0; k < num_lanes; k++) begin
            if (wt_be[k]) par_r[wt_addr][k] <= wr_par_s[k];
          end
        end
      end
      assign rd_par_s = par_r[rd_addr];
    end else begin : g_nopar
      assign rd_par_s = '0;
    end
  endgenerate

  assign rd_err_s = (parity_en != 0) ? (lane_parity(mem_r[rd_addr]) ^ rd_par_s) : '0;

  // Read stage 1: capture word and its parity check on rd_en; data holds otherwise.
  always_ff @(posedge rd_clk_dp_ram or negedge rd_rst_n_dp_ram_in) begin
    if (!rd_rst_n_dp_ram_in) begin
      s1_data_r <= '0;
      s1_vld_r  <= 1'b0;
      s1_err_r  <= '0;
    end else begin
      s1_vld_r <= rd_en_dp_ram;
      s1_err_r <= rd_en_dp_ram ? rd_err_s : '0;
      if (rd_en_dp_ram) s1_data_r <= mem_r[rd_addr];
    end
  end

  generate
    if (read_latency == 2) begin : g_lat2
      logic [W-1:0]         o_data_r;
      logic                 o_vld_r;
      logic [num_lanes-1:0] o_err_r;
      // Optional output stage adds one read clock.
      always_ff @(posedge rd_clk_dp_ram or negedge rd_rst_n_dp_ram_in) begin
        if (!rd_rst_n_dp_ram_in) begin
          o_data_r <= '0;
          o_vld_r  <= 1'b0;
          o_err_r  <= '0;
        end else begin
          o_vld_r <= s1_vld_r;
          o_err_r <= s1_vld_r ? s1_err_r : '0;
          if (s1_vld_r) o_data_r <= s1_data_r;
        end
      end
      assign data_out_dp_ram = o_data_r;
      assign rd_valid        = o_vld_r;
      assign rd_parity_err   = o_err_r;
    end else begin : g_lat1
      assign data_out_dp_ram = s1_data_r;
      assign rd_valid        = s1_vld_r;
      assign rd_parity_err   = s1_err_r;
    end
  endgenerate

  assign wt_ready  = wt_ready_r;
  assign init_done = init_done_r;
  assign wt_drop   = wt_drop_r;

endmodule
